// File: rtl/imem_responder_if.sv
// -----------------------------------------------------------------------------
// imem_responder_if
//   Instruction fetch request/acknowledge bus between a fetch unit (master)
//   and a memory-side responder (slave).
//
//   m_req       master -> slave  request valid, held while words are wanted
//   m_req_addr  master -> slave  byte address of the requested word
//   m_ack       slave  -> master one-cycle pulse, data_out/m_err valid
//   data_out    slave  -> master returned instruction word
//   m_err       slave  -> master qualifies m_ack: misaligned or out of range
// -----------------------------------------------------------------------------
interface imem_responder_if;
  logic        m_req;
  logic [31:0] m_req_addr;
  logic        m_ack;
  logic [31:0] data_out;
  logic        m_err;

  modport master (
    output m_req,
    output m_req_addr,
    input  m_ack,
    input  data_out,
    input  m_err
  );

  modport slave (
    input  m_req,
    input  m_req_addr,
    output m_ack,
    output data_out,
    output m_err
  );
endinterface

// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//   Memory-side responder for the instruction fetch bus. A request is latched
//   in IDLE, counted down for LATENCY cycles in BUSY, then answered with a
//   single-cycle m_ack in RESP. The backing array is word addressed and is
//   filled through a side preload port that may write in any state.
//
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   bus       fetch bus (slave side): m_req, m_req_addr, m_ack, data_out, m_err
//   ld_en     preload write enable
//   ld_addr   preload word index
//   ld_data   preload write data
// -----------------------------------------------------------------------------
module imem_responder #(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  imem_responder_if.slave          bus,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data
);

  localparam int AW = $clog2(DEPTH);
  // Countdown holds LATENCY-1; keep at least one bit so LATENCY=1 still works.
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [31:0]   SPAN     = 32'(DEPTH) << 2;
  localparam logic [31:0]   NOP_WORD = 32'h0000_0013;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [31:0]   mem_r [DEPTH];
  logic [1:0]    state_r;
  logic [CW-1:0] cnt_r;
  logic [31:0]   lat_addr_r;
  logic          m_ack_r;
  logic          m_err_r;
  logic [31:0]   data_out_r;

  logic [31:0]   off_s;
  logic          abort_s;
  logic          resp_err_s;
  logic [31:0]   resp_data_s;

  // Response selection from the latched address; the array read happens here
  // so the registered load at the RESP edge sees pre-write contents.
  always_comb begin
    off_s       = lat_addr_r - BASE_ADDR;
    resp_err_s  = 1'b0;
    resp_data_s = NOP_WORD;
    if (lat_addr_r[1:0] != 2'b00) begin
      resp_err_s  = 1'b1;
      resp_data_s = NOP_WORD;
    end else if (off_s >= SPAN) begin
      // Addresses below BASE_ADDR wrap to huge offsets and land here too.
      resp_err_s  = 1'b1;
      resp_data_s = NOP_WORD;
    end else begin
      resp_err_s  = 1'b0;
      resp_data_s = mem_r[off_s[AW+1:2]];
    end
  end

  // A BUSY request is dropped when the requester withdraws or redirects.
  always_comb begin
    abort_s = 1'b0;
    if (!bus.m_req || (bus.m_req_addr != lat_addr_r)) begin
      abort_s = 1'b1;
    end else begin
      abort_s = 1'b0;
    end
  end

  // Preload port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem_r[ld_addr] <= ld_data;
    end
  end

  // Request FSM with registered response outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO;
      lat_addr_r <= 32'h0000_0000;
      m_ack_r    <= 1'b0;
      m_err_r    <= 1'b0;
      data_out_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.m_req) begin
            lat_addr_r <= bus.m_req_addr;
            cnt_r      <= CNT_INIT;
            state_r    <= ST_BUSY;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (abort_s) begin
            state_r <= ST_IDLE;
          end else if (cnt_r != CNT_ZERO) begin
            cnt_r   <= cnt_r - CNT_ONE;
          end else begin
            state_r    <= ST_RESP;
            m_ack_r    <= 1'b1;
            m_err_r    <= resp_err_s;
            data_out_r <= resp_data_s;
          end
        end
        ST_RESP: begin
          // The ack is committed; an address change here cannot retract it.
          m_ack_r <= 1'b0;
          m_err_r <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          m_ack_r <= 1'b0;
          m_err_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.m_ack    = m_ack_r;
  assign bus.m_err    = m_err_r;
  assign bus.data_out = data_out_r;

endmodule

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
//   Directed plus randomized bench for imem_responder. A word-array model of
//   the memory and the response rules predict every ack's data, error flag
//   and the number of clock edges from driving a request to seeing its ack.
// -----------------------------------------------------------------------------
module tb_imem_responder;

  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk;
  logic          reset_n;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;

  imem_responder_if bus ();

  imem_responder #(
    .DEPTH    (DEPTH),
    .LATENCY  (LAT),
    .BASE_ADDR(BASE)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus),
    .ld_en  (ld_en),
    .ld_addr(ld_addr),
    .ld_data(ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_mem [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = AW'(idx);
    ld_data = d;
    tick();
    ld_en   = 1'b0;
    model_mem[idx] = d;
  endtask

  // Expected {err, data} from the response rules.
  function automatic logic [32:0] ref_resp(input logic [31:0] a);
    logic [31:0] off;
    if ((a % 32'd4) != 32'd0) return {1'b1, NOP};
    off = a - BASE;
    if (off >= 32'(DEPTH) * 32'd4) return {1'b1, NOP};
    return {1'b0, model_mem[off / 32'd4]};
  endfunction

  // Drive a request and count edges until its ack; m_req stays high afterwards.
  task automatic fetch(input logic [31:0] a, input int exp_edges, input string tag);
    logic [32:0] e;
    int  n;
    bit  seen;
    e = ref_resp(a);
    bus.m_req      = 1'b1;
    bus.m_req_addr = a;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (bus.m_ack === 1'b1) seen = 1'b1;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_edges));
    if (seen) begin
      chk({tag, "_data"}, bus.data_out, e[31:0]);
      chk({tag, "_err"}, {31'd0, bus.m_err}, {31'd0, e[32]});
    end
  endtask

  // Release the request and let the FSM leave RESP.
  task automatic drop();
    bus.m_req = 1'b0;
    tick();
    chk("ack_pulse_one_cycle", {31'd0, bus.m_ack}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] old5;
    int mode;
    bit keep;
    int next_exp;

    reset_n        = 1'b0;
    bus.m_req      = 1'b0;
    bus.m_req_addr = 32'h0000_0000;
    ld_en          = 1'b0;
    ld_addr        = '0;
    ld_data        = 32'h0000_0000;
    #3;
    chk("reset_ack", {31'd0, bus.m_ack}, 32'd0);
    chk("reset_err", {31'd0, bus.m_err}, 32'd0);
    chk("reset_data", bus.data_out, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Fill the whole array, then place the directed words.
    for (int i = 0; i < DEPTH; i++) load(i, $urandom);
    for (int i = 0; i < 4; i++) load(i, 32'hA0 + 32'(i));
    load(5, 32'h0000_0055);
    load(16, 32'hC0DE_0016);

    // Streaming fetch with m_req held: first ack after LAT+1 edges, then LAT+2.
    fetch(32'h0, LAT + 1, "stream0");
    chk("stream0_word", bus.data_out, 32'hA0);
    fetch(32'h4, LAT + 2, "stream1");
    fetch(32'h8, LAT + 2, "stream2");
    fetch(32'hC, LAT + 2, "stream3");
    chk("stream3_word", bus.data_out, 32'hA3);
    drop();

    // Misaligned and just-past-the-end requests.
    fetch(32'h2, LAT + 1, "misaligned");
    chk("misaligned_nop", bus.data_out, NOP);
    drop();
    fetch(32'h1000, LAT + 1, "out_of_range");
    chk("oor_err", {31'd0, bus.m_err}, 32'd1);
    drop();

    // Redirect one cycle into BUSY: no ack for 0x8, then 0x40 is served.
    bus.m_req      = 1'b1;
    bus.m_req_addr = 32'h8;
    tick();
    chk("redirect_no_ack", {31'd0, bus.m_ack}, 32'd0);
    fetch(32'h40, LAT + 2, "redirect");
    chk("redirect_word", bus.data_out, 32'hC0DE_0016);
    drop();

    // Withdraw after one BUSY cycle: silence for 10 cycles.
    bus.m_req      = 1'b1;
    bus.m_req_addr = 32'h0;
    tick();
    tick();
    bus.m_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("withdraw_silent", {31'd0, bus.m_ack}, 32'd0);
    end
    fetch(32'h4, LAT + 1, "after_withdraw");
    drop();

    // Preload at the edge entering RESP returns the old word.
    old5           = model_mem[5];
    bus.m_req      = 1'b1;
    bus.m_req_addr = 32'h14;
    for (int i = 0; i < LAT; i++) begin
      tick();
      chk("rbw_wait", {31'd0, bus.m_ack}, 32'd0);
    end
    ld_en   = 1'b1;
    ld_addr = AW'(5);
    ld_data = 32'h0000_DEAD;
    tick();
    ld_en = 1'b0;
    model_mem[5] = 32'h0000_DEAD;
    chk("rbw_ack", {31'd0, bus.m_ack}, 32'd1);
    chk("rbw_old", bus.data_out, old5);
    drop();
    fetch(32'h14, LAT + 1, "rbw_new");
    chk("rbw_new_word", bus.data_out, 32'h0000_DEAD);
    drop();

    // Asynchronous reset in the middle of BUSY.
    bus.m_req      = 1'b1;
    bus.m_req_addr = 32'h0;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_ack", {31'd0, bus.m_ack}, 32'd0);
    chk("async_rst_data", bus.data_out, 32'd0);
    chk("async_rst_err", {31'd0, bus.m_err}, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    fetch(32'h0, LAT + 1, "post_reset");
    drop();

    // Randomized requests, preloads, aborts and back-to-back streaming.
    next_exp = LAT + 1;
    for (int it = 0; it < 60; it++) begin
      mode = $urandom_range(0, 4);
      case (mode)
        0, 1: a = {20'd0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
        2:    a = {20'd0, 10'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
        3:    a = 32'(DEPTH) * 32'd4 + 32'd4 * 32'($urandom_range(0, 4000));
        default: a = 32'hFFFF_FFFC - 32'd4 * 32'($urandom_range(0, 15));
      endcase
      if (next_exp == LAT + 1 && $urandom_range(0, 3) == 0) begin
        bus.m_req      = 1'b1;
        bus.m_req_addr = a ^ 32'h0000_0100;
        tick();
        chk("rand_abort_no_ack", {31'd0, bus.m_ack}, 32'd0);
        next_exp = LAT + 2;
      end
      fetch(a, next_exp, "rand");
      keep = 1'($urandom_range(0, 1));
      if (keep) begin
        next_exp = LAT + 2;
      end else begin
        drop();
        if ($urandom_range(0, 1) == 1) load($urandom_range(0, DEPTH - 1), $urandom);
        next_exp = LAT + 1;
      end
    end
    bus.m_req = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
